// File: rtl/csc_pkg.sv
// rtl/csc_pkg.sv - shared BT.601 full-range colour-space constants and helpers
package csc_pkg;

  localparam int FRAC     = 8;
  localparam int OFFSET_C = 128;
  localparam int ROUND    = 128;

  localparam logic signed [9:0] C_RCR = 10'sd359;
  localparam logic signed [9:0] C_GCB = 10'sd88;
  localparam logic signed [9:0] C_GCR = 10'sd183;
  localparam logic signed [9:0] C_BCB = 10'sd454;

  // idx 2 -> [23:16], idx 1 -> [15:8], idx 0 -> [7:0]
  function automatic logic [7:0] pix_field(input logic [23:0] pix, input int idx);
    return pix[idx*8 +: 8];
  endfunction

  function automatic logic [7:0] sat8(input logic signed [11:0] val);
    logic [7:0] res;
    if (val < 12'sd0) begin
      res = 8'd0;
    end else if (val > 12'sd255) begin
      res = 8'd255;
    end else begin
      res = val[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/ycbcr_sync_delay.sv
// rtl/ycbcr_sync_delay.sv - N-deep shift register for the {v,h,de} sync bundle
module ycbcr_sync_delay
  import csc_pkg::*;
#(
  parameter int W = 3,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         de_pre
);

  logic [W-1:0] stage_d [N];
  logic [W-1:0] stage_q [N];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < N; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[N-1];
  // de is bit 0 of the bundle; this tap lines up with the final pixel stage input
  assign de_pre = stage_q[N-2][0];

endmodule

// File: rtl/ycbcr2rgb.sv
// rtl/ycbcr2rgb.sv - 4-stage YCbCr 4:4:4 to RGB converter with matched sync delay
// Optional YCBCR2RGB_BLANK_EN: force RGB to black whenever the delayed de is low.
module ycbcr2rgb
  import csc_pkg::*;
#(
  parameter int FRAC   = 8,
  parameter int SYNC_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] YCbCr,
  input  logic        in_v,
  input  logic        in_h,
  input  logic        in_de,
  output logic [23:0] RGB,
  output logic        out_v,
  output logic        out_h,
  output logic        out_de
);

`ifdef YCBCR2RGB_BLANK_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  logic signed [19:0] y_term_d, y_term_q;
  logic signed [8:0]  dcb_d, dcb_q, dcr_d, dcr_q;

  logic signed [19:0] y2_d, y2_q;
  logic signed [18:0] p_rcr_d, p_rcr_q, p_gcb_d, p_gcb_q;
  logic signed [18:0] p_gcr_d, p_gcr_q, p_bcb_d, p_bcb_q;

  logic signed [19:0] sum_r_d, sum_r_q, sum_g_d, sum_g_q, sum_b_d, sum_b_q;

  logic [23:0]        rgb_d, rgb_q;
  logic [SYNC_W-1:0]  sync_out;
  logic               de_s3;

  always_comb begin
    // S1: Y scaled with rounding folded in, chroma re-centred around zero
    y_term_d = $signed({4'd0, pix_field(YCbCr, 2), 8'd0}) + 20'(ROUND);
    dcr_d    = $signed({1'b0, pix_field(YCbCr, 1)}) - 9'(OFFSET_C);
    dcb_d    = $signed({1'b0, pix_field(YCbCr, 0)}) - 9'(OFFSET_C);

    y2_d    = y_term_q;
    p_rcr_d = 19'(C_RCR) * 19'(dcr_q);
    p_gcb_d = 19'(C_GCB) * 19'(dcb_q);
    p_gcr_d = 19'(C_GCR) * 19'(dcr_q);
    p_bcb_d = 19'(C_BCB) * 19'(dcb_q);

    sum_r_d = y2_q + 20'(p_rcr_q);
    sum_g_d = y2_q - 20'(p_gcb_q) - 20'(p_gcr_q);
    sum_b_d = y2_q + 20'(p_bcb_q);

    // Output packing is {R, B, G}, matching the forward converter
    rgb_d = {sat8(12'(sum_r_q >>> FRAC)),
             sat8(12'(sum_b_q >>> FRAC)),
             sat8(12'(sum_g_q >>> FRAC))};
    if (BLANK_EN && !de_s3) begin
      rgb_d = 24'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_term_q <= '0;
      dcb_q    <= '0;
      dcr_q    <= '0;
      y2_q     <= '0;
      p_rcr_q  <= '0;
      p_gcb_q  <= '0;
      p_gcr_q  <= '0;
      p_bcb_q  <= '0;
      sum_r_q  <= '0;
      sum_g_q  <= '0;
      sum_b_q  <= '0;
      rgb_q    <= '0;
    end else begin
      y_term_q <= y_term_d;
      dcb_q    <= dcb_d;
      dcr_q    <= dcr_d;
      y2_q     <= y2_d;
      p_rcr_q  <= p_rcr_d;
      p_gcb_q  <= p_gcb_d;
      p_gcr_q  <= p_gcr_d;
      p_bcb_q  <= p_bcb_d;
      sum_r_q  <= sum_r_d;
      sum_g_q  <= sum_g_d;
      sum_b_q  <= sum_b_d;
      rgb_q    <= rgb_d;
    end
  end

  ycbcr_sync_delay #(
    .W (SYNC_W),
    .N (4)
  ) u_sync_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    ({in_v, in_h, in_de}),
    .dout   (sync_out),
    .de_pre (de_s3)
  );

  assign RGB    = rgb_q;
  assign out_v  = sync_out[2];
  assign out_h  = sync_out[1];
  assign out_de = sync_out[0];

endmodule

// File: tb/tb_ycbcr2rgb.sv
// tb/tb_ycbcr2rgb.sv - directed self-checking bench for ycbcr2rgb
module tb_ycbcr2rgb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] YCbCr;
  logic        in_v, in_h, in_de;
  logic [23:0] RGB;
  logic        out_v, out_h, out_de;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ycbcr2rgb dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .YCbCr  (YCbCr),
    .in_v   (in_v),
    .in_h   (in_h),
    .in_de  (in_de),
    .RGB    (RGB),
    .out_v  (out_v),
    .out_h  (out_h),
    .out_de (out_de)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pix packed {Y, Cr, Cb}; sync packed {v, h, de}
  task automatic drive(input logic [23:0] pix, input logic [2:0] sync);
    YCbCr = pix;
    {in_v, in_h, in_de} = sync;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive({8'd200, 8'd30, 8'd77}, 3'b111);
    step();
    step();
    checks++;
    if (RGB !== 24'h0) begin
      failures++;
      $display("FAIL reset_rgb got=%h want=%h", RGB, 24'h0);
    end
    checks++;
    if ({out_v, out_h, out_de} !== 3'b000) begin
      failures++;
      $display("FAIL reset_sync got=%b want=%b", {out_v, out_h, out_de}, 3'b000);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    logic [23:0] exp_rgb [3];
    exp_rgb[0] = 24'h000088;
    exp_rgb[1] = 24'h808080;
    exp_rgb[2] = 24'h000088;
    drive(24'h000000, 3'b000);
    for (int i = 0; i < 5; i++) step();
    drive({8'd128, 8'd128, 8'd128}, 3'b000);
    step();
    drive(24'h000000, 3'b000);
    step();
    step();
    // the 128/128/128 pixel must surface exactly after the 4th edge
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (RGB !== exp_rgb[i]) begin
        failures++;
        $display("FAIL latency_%0d got=%h want=%h", i, RGB, exp_rgb[i]);
      end
      step();
    end
  endtask

  task automatic test_pixels();
    logic [23:0] pix [4];
    logic [23:0] exp_rgb [4];
    pix[0] = {8'd128, 8'd128, 8'd128};  exp_rgb[0] = 24'h808080;
    pix[1] = {8'd255, 8'd255, 8'd128};  exp_rgb[1] = 24'hFFFFA4;
    pix[2] = {8'd0,   8'd0,   8'd0};    exp_rgb[2] = 24'h000088;
    pix[3] = {8'd81,  8'd240, 8'd90};   exp_rgb[3] = 24'hEE0E0E;
    for (int i = 0; i < 4; i++) begin
      drive(pix[i], 3'b001);
      for (int k = 0; k < 4; k++) step();
      checks++;
      if (RGB !== exp_rgb[i]) begin
        failures++;
        $display("FAIL pixel_%0d got=%h want=%h", i, RGB, exp_rgb[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] pix [4];
    logic [23:0] exp_rgb [4];
    pix[0] = {8'd81,  8'd240, 8'd90};   exp_rgb[0] = 24'hEE0E0E;
    pix[1] = {8'd0,   8'd0,   8'd0};    exp_rgb[1] = 24'h000088;
    pix[2] = {8'd255, 8'd255, 8'd128};  exp_rgb[2] = 24'hFFFFA4;
    pix[3] = {8'd128, 8'd128, 8'd128};  exp_rgb[3] = 24'h808080;
    for (int i = 0; i < 7; i++) begin
      drive((i < 4) ? pix[i] : pix[3], 3'b001);
      step();
      if (i >= 3) begin
        checks++;
        if (RGB !== exp_rgb[i-3]) begin
          failures++;
          $display("FAIL b2b_%0d got=%h want=%h", i - 3, RGB, exp_rgb[i-3]);
        end
      end
    end
  endtask

  task automatic test_sync();
    logic [2:0]  seq [5];
    logic [2:0]  exp_sync;
    logic [23:0] exp_rgb;
    seq[0] = 3'b001;
    seq[1] = 3'b110;
    seq[2] = 3'b001;
    seq[3] = 3'b000;
    seq[4] = 3'b000;
    drive({8'd128, 8'd128, 8'd128}, 3'b000);
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 8; i++) begin
      drive({8'd128, 8'd128, 8'd128}, (i < 5) ? seq[i] : 3'b000);
      step();
      exp_sync = (i >= 3 && i - 3 < 5) ? seq[i-3] : 3'b000;
`ifdef YCBCR2RGB_BLANK_EN
      exp_rgb = exp_sync[0] ? 24'h808080 : 24'h0;
`else
      exp_rgb = 24'h808080;
`endif
      checks++;
      if ({out_v, out_h, out_de} !== exp_sync) begin
        failures++;
        $display("FAIL sync_%0d got=%b want=%b", i, {out_v, out_h, out_de}, exp_sync);
      end
      checks++;
      if (RGB !== exp_rgb) begin
        failures++;
        $display("FAIL sync_rgb_%0d got=%h want=%h", i, RGB, exp_rgb);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [23:0] exp_rgb;
    logic [2:0]  exp_sync;
    drive({8'd128, 8'd128, 8'd128}, 3'b111);
    for (int i = 0; i < 6; i++) step();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (RGB !== 24'h0 || {out_v, out_h, out_de} !== 3'b000) begin
        failures++;
        $display("FAIL midrst_hold_%0d got=%h/%b want=%h/%b", i, RGB,
                 {out_v, out_h, out_de}, 24'h0, 3'b000);
      end
    end
    rst_n = 1'b1;
    drive({8'd81, 8'd240, 8'd90}, 3'b111);
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_rgb  = (i >= 4) ? 24'hEE0E0E : 24'h0;
      exp_sync = (i >= 4) ? 3'b111 : 3'b000;
      checks++;
      if (RGB !== exp_rgb || {out_v, out_h, out_de} !== exp_sync) begin
        failures++;
        $display("FAIL midrst_release_%0d got=%h/%b want=%h/%b", i, RGB,
                 {out_v, out_h, out_de}, exp_rgb, exp_sync);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(24'h0, 3'b000);
    test_reset();
    test_latency();
    test_pixels();
    test_back_to_back();
    test_sync();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
